// File: rtl/stream_mux_arb.sv
// -----------------------------------------------------------------------------
// stream_mux_arb
//   N-input registered stream multiplexer with an internal arbiter. Each
//   producer channel offers a word with valid/ready. The arbiter picks one
//   channel per cycle, either by fixed priority (lowest index wins) or by
//   round robin. The chosen word is captured into a single output register.
//   The register reloads on the same edge that its word is consumed, so the
//   block sustains one word per cycle with no bubbles.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   rr_en      1 = round robin, 0 = fixed priority
//   in_data    packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (one-hot or zero)
//   out_data   registered selected word
//   out_sel    index of the channel that produced out_data
//   out_valid  output register holds a word
//   out_ready  consumer accepts the output word
// -----------------------------------------------------------------------------
module stream_mux_arb #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rr_en,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0]    data_p0;
  logic [SEL_W-1:0]    sel_p0;
  logic                vld_p0;
  logic [SEL_W-1:0]    rr_last;

  logic                load;
  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    gsel;
  logic                any;
  logic [SEL_W-1:0]    cand;

  // The register may take a new word whenever it is empty or being drained.
  assign load = !vld_p0 || out_ready;

  // Round robin starts the search just after the last winner and finishes on
  // the last winner itself, so a lone requester is never starved.
  always_comb begin
    grant = '0;
    gsel  = '0;
    any   = 1'b0;
    cand  = '0;
    if (!rr_en) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!any && in_valid[i]) begin
          grant[i] = 1'b1;
          gsel     = SEL_W'(i);
          any      = 1'b1;
        end
      end
    end else begin
      for (int k = 1; k <= CHANNELS; k++) begin
        cand = SEL_W'((int'(rr_last) + k) % CHANNELS);
        if (!any && in_valid[cand]) begin
          grant[cand] = 1'b1;
          gsel        = cand;
          any         = 1'b1;
        end
      end
    end
  end

  assign in_ready = {CHANNELS{load}} & grant;

  // ---- stage p0: output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      sel_p0  <= '0;
      rr_last <= SEL_W'(CHANNELS - 1);
    end else if (load) begin
      if (any) begin
        vld_p0  <= 1'b1;
        data_p0 <= in_data[int'(gsel)*WIDTH +: WIDTH];
        sel_p0  <= gsel;
        rr_last <= gsel;
      end else begin
        vld_p0  <= 1'b0;
      end
    end
  end

  assign out_data  = data_p0;
  assign out_sel   = sel_p0;
  assign out_valid = vld_p0;

endmodule

// File: tb/tb_stream_mux_arb.sv
module tb_stream_mux_arb;

  logic        clk;
  logic        rst;
  logic        rr_en;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [3:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;

  logic [11:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [3:0]  out_data3;
  logic [1:0]  out_sel3;
  logic        out_valid3;

  stream_mux_arb #(.WIDTH(4), .CHANNELS(4), .SEL_W(2)) dut4 (
    .clk(clk), .rst(rst), .rr_en(rr_en),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  stream_mux_arb #(.WIDTH(4), .CHANNELS(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst(rst), .rr_en(rr_en),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_sel(out_sel3), .out_valid(out_valid3),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        rst;
    logic        rr;
    logic [3:0]  iv;
    logic        ordy;
    logic [15:0] din;
    logic [3:0]  rdy;
    logic        vld;
    logic [3:0]  dat;
    logic [1:0]  sel;
  } vec_t;

  typedef struct {
    logic [3:0] dat;
    logic [1:0] sel;
  } word_t;

  vec_t  tbl[$];
  word_t sb[$];
  int    total = 0;
  int    bad   = 0;

  task automatic add(input logic r, input logic rr, input logic [3:0] iv,
                     input logic ordy, input logic [15:0] din,
                     input logic [3:0] rdy, input logic vld,
                     input logic [3:0] dat, input logic [1:0] sel);
    vec_t v;
    v.rst = r; v.rr = rr; v.iv = iv; v.ordy = ordy; v.din = din;
    v.rdy = rdy; v.vld = vld; v.dat = dat; v.sel = sel;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%0h want=%0h", nm, row, act, exp);
    end
  endtask

  initial begin
    vec_t  v;
    word_t w;

    rst = 1'b1; rr_en = 1'b0; in_data = '0; in_valid = '0; out_ready = 1'b1;
    in_data3 = '0; in_valid3 = '0;

    //   rst rr  iv       ordy din       rdy      vld  dat    sel
    // reset, then a single channel
    add(1, 0, 4'b0000, 1, 16'h0000, 4'b0000, 0, 4'h0, 2'd0);
    add(1, 0, 4'b0000, 1, 16'h0000, 4'b0000, 0, 4'h0, 2'd0);
    add(0, 0, 4'b0100, 1, 16'h0A00, 4'b0100, 1, 4'hA, 2'd2);
    // fixed priority
    add(0, 0, 4'b1111, 1, 16'h4321, 4'b0001, 1, 4'h1, 2'd0);
    add(0, 0, 4'b1111, 1, 16'h4321, 4'b0001, 1, 4'h1, 2'd0);
    add(0, 0, 4'b1111, 1, 16'h4321, 4'b0001, 1, 4'h1, 2'd0);
    // round robin from reset
    add(1, 1, 4'b1111, 1, 16'h4321, 4'b0000, 0, 4'h0, 2'd0);
    add(0, 1, 4'b1111, 1, 16'h4321, 4'b0001, 1, 4'h1, 2'd0);
    add(0, 1, 4'b1111, 1, 16'h4321, 4'b0010, 1, 4'h2, 2'd1);
    add(0, 1, 4'b1111, 1, 16'h4321, 4'b0100, 1, 4'h3, 2'd2);
    add(0, 1, 4'b1111, 1, 16'h4321, 4'b1000, 1, 4'h4, 2'd3);
    add(0, 1, 4'b1111, 1, 16'h4321, 4'b0001, 1, 4'h1, 2'd0);
    add(0, 1, 4'b1111, 1, 16'h4321, 4'b0010, 1, 4'h2, 2'd1);
    add(0, 1, 4'b1010, 1, 16'h4321, 4'b1000, 1, 4'h4, 2'd3);
    add(0, 1, 4'b1010, 1, 16'h4321, 4'b0010, 1, 4'h2, 2'd1);
    add(0, 1, 4'b1010, 1, 16'h4321, 4'b1000, 1, 4'h4, 2'd3);
    add(0, 1, 4'b1010, 1, 16'h4321, 4'b0010, 1, 4'h2, 2'd1);
    // backpressure: hold 5 for three cycles, then consume and reload
    add(0, 0, 4'b0001, 1, 16'h0005, 4'b0001, 1, 4'h5, 2'd0);
    add(0, 0, 4'b0010, 0, 16'h0060, 4'b0000, 1, 4'h5, 2'd0);
    add(0, 0, 4'b0010, 0, 16'h0060, 4'b0000, 1, 4'h5, 2'd0);
    add(0, 0, 4'b0010, 0, 16'h0060, 4'b0000, 1, 4'h5, 2'd0);
    add(0, 0, 4'b0010, 1, 16'h0060, 4'b0010, 1, 4'h6, 2'd1);
    // drain
    add(0, 0, 4'b0000, 1, 16'h0000, 4'b0000, 0, 4'h6, 2'd1);
    add(0, 0, 4'b0000, 1, 16'h0000, 4'b0000, 0, 4'h6, 2'd1);
    // empty register loads even while the consumer stalls
    add(0, 0, 4'b0100, 0, 16'h0700, 4'b0100, 1, 4'h7, 2'd2);
    add(0, 0, 4'b0100, 0, 16'h0700, 4'b0000, 1, 4'h7, 2'd2);
    // mode changes keep the pointer; fixed mode still updates it
    add(0, 1, 4'b1111, 1, 16'h4321, 4'b1000, 1, 4'h4, 2'd3);
    add(0, 0, 4'b1111, 1, 16'h4321, 4'b0001, 1, 4'h1, 2'd0);
    add(0, 1, 4'b1111, 1, 16'h4321, 4'b0010, 1, 4'h2, 2'd1);
    // reset mid-stream, channel 0 wins first afterwards
    add(1, 1, 4'b1111, 1, 16'h4321, 4'b0000, 0, 4'h0, 2'd0);
    add(0, 1, 4'b1111, 1, 16'h4321, 4'b0001, 1, 4'h1, 2'd0);
    add(0, 1, 4'b0000, 1, 16'h4321, 4'b0000, 0, 4'h1, 2'd0);

    for (int r = 0; r < tbl.size(); r++) begin
      v = tbl[r];
      rst = v.rst; rr_en = v.rr; in_valid = v.iv; out_ready = v.ordy;
      in_data = v.din;
      #1;
      if (!v.rst) begin
        chk("in_ready", r, 32'(in_ready), 32'(v.rdy));
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("sb_level", r, 32'(sb.size()), 32'd1);
          end else begin
            w = sb.pop_front();
            chk("sb_data", r, 32'(out_data), 32'(w.dat));
            chk("sb_sel", r, 32'(out_sel), 32'(w.sel));
          end
        end
        for (int c = 0; c < 4; c++) begin
          if (v.rdy[c]) begin
            w.dat = v.din[c*4 +: 4];
            w.sel = 2'(c);
            sb.push_back(w);
          end
        end
      end else begin
        sb.delete();
      end
      @(posedge clk);
      #1;
      chk("out_valid", r, 32'(out_valid), 32'(v.vld));
      chk("out_data", r, 32'(out_data), 32'(v.dat));
      chk("out_sel", r, 32'(out_sel), 32'(v.sel));
    end
    chk("sb_final", -1, 32'(sb.size()), 32'd0);

    // three-channel round robin wraps 0,1,2,0 and never reaches 3
    rst = 1'b1; in_valid = '0; in_valid3 = '0; rr_en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("rst3_vld", 100 + i, 32'(out_valid3), 32'd0);
      chk("rst3_data", 100 + i, 32'(out_data3), 32'd0);
    end
    rst = 1'b0; in_valid3 = 3'b111; in_data3 = 12'h321;
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("rdy3", 200 + i, 32'(in_ready3), 32'(3'b001 << (i % 3)));
      @(posedge clk);
      #1;
      chk("vld3", 200 + i, 32'(out_valid3), 32'd1);
      chk("sel3", 200 + i, 32'(out_sel3), 32'(i % 3));
      chk("data3", 200 + i, 32'(out_data3), 32'((i % 3) + 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_mux_arb.md
Name: stream_mux_arb

Overview:
- Parametrised N-input, WIDTH-bit registered multiplexer.
- Each input channel has a valid/ready handshake. An internal arbiter chooses the source; the software select of the 4:1 mux is replaced by arbitration.
- Arbitration mode is selectable at run time: fixed priority or round robin.
- Sits between several producer channels and one consumer.
- The output is a single register stage with full throughput and no bubbles under backpressure.

Parameters:
- WIDTH, 4, data width per channel.
- CHANNELS, 4, number of input channels (2..16).
- SEL_W, 2, width of the channel index. Must equal ceil(log2(CHANNELS)).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- rr_en  input  1  arbitration mode: 1 = round robin, 0 = fixed priority (lowest index wins).
- in_data  input  CHANNELS*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready; at most one bit is set per cycle.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  SEL_W  index of the channel that produced out_data.
- out_valid  output  1  output holds a word.
- out_ready  input  1  consumer accepts the output word.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_sel=0, round-robin pointer last=CHANNELS-1. With that pointer, channel 0 has top round-robin priority after reset.
- Load enable: load = !out_valid || out_ready. This is combinational.
- Grant (combinational, one-hot or zero):
  - rr_en=0: the lowest-index i with in_valid[i]=1.
  - rr_en=1: the first i with in_valid[i]=1, searching last+1, last+2, ..., wrapping modulo CHANNELS, and ending with last itself.
- Ready: in_ready[i] = load && grant[i].
  - in_ready depends combinationally on in_valid and out_ready.
  - Producers must not make in_valid depend on in_ready.
- Transfer on input i: in_valid[i] && in_ready[i] at a clock edge. On that edge:
  - out_data <= in_data[i]
  - out_sel <= i
  - out_valid <= 1
  - last <= i (last updates in both modes)
- Output hold: if load=1 and no in_valid bit is set, out_valid <= 0. out_data and out_sel keep their old values.
- Output stall: if out_valid=1 and out_ready=0, out_data, out_sel and out_valid hold, and all in_ready bits are 0.
- Latency: 1 cycle from input transfer to out_valid. Throughput: 1 word per cycle when out_ready is held at 1.
- Simultaneous consume and load: when out_ready=1 and out_valid=1, the output word is consumed and a new word is loaded on the same edge. There is no bubble.
- Mode change: rr_en may change on any cycle. It takes effect on that cycle's grant. The pointer is never cleared by a mode change.
- Reset mid-operation: rst overrides all transfers on that edge. Words in flight are dropped, and in_ready is don't-care during the rst cycle.
- Channel data is never modified. Widths are exact and there is no arithmetic.
- Protocol: producers hold in_data and in_valid stable until they are accepted. The block does not check this.

Test Plan:
- Reset, then single channel:
  - Stimulus: rst high for 2 cycles, then in_valid=4'b0100, in_data ch2=4'hA, out_ready=1.
  - Required: out_valid=0 and out_data=0 during reset. After one edge, out_valid=1, out_data=4'hA, out_sel=2, and in_ready was 4'b0100 in the transfer cycle.
- Fixed priority:
  - Stimulus: rr_en=0, in_valid=4'b1111 continuously, out_ready=1, data ch0..ch3 = 1,2,3,4.
  - Required: every output word is 1 with out_sel=0; in_ready=4'b0001 every cycle.
- Round robin:
  - Stimulus: rr_en=1, in_valid=4'b1111 continuously, out_ready=1, data ch0..ch3 = 1,2,3,4.
  - Required: out_sel sequence after reset is 0,1,2,3,0,1; out_data sequence is 1,2,3,4,1,2.
  - Then set in_valid=4'b1010. Required: out_sel alternates 1,3,1,3.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles with out_valid=1 and out_data=4'h5.
  - Required: out_data stays 4'h5 and in_ready=0 for all 3 cycles.
  - Then raise out_ready. Required: 4'h5 is consumed and the next word is loaded on the same edge, with no bubble.
- Drain:
  - Stimulus: out_valid=1, out_ready=1, in_valid=0.
  - Required: out_valid goes to 0 on the next edge; out_data and out_sel keep their last values.
- Reset mid-stream and CHANNELS=3:
  - Stimulus: assert rst during round-robin traffic.
  - Required: next cycle out_valid=0, and the first grant after reset goes to ch0.
  - Stimulus: rerun the round-robin test with CHANNELS=3, SEL_W=2.
  - Required: out_sel wraps 0,1,2,0, and never shows 3.
